// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO in front of the UART transmitter. Bytes written
// from the I/O path are queued and handed to the transmitter one at a time
// over a start/data/done handshake, with at most one byte outstanding.
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  clear_overflow,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  idle,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wp;
    logic [DEPTH_LOG2-1:0]  rp;
    logic [DEPTH_LOG2:0]    count_q;
    logic                   overflow_q;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   start_next;

    // Fill level after one cycle of pushes and pops; both at once cancel out.
    function automatic logic [DEPTH_LOG2:0] next_count(
        input logic [DEPTH_LOG2:0] cur,
        input logic                inc,
        input logic                dec
    );
        logic [DEPTH_LOG2:0] res;
        res = cur;
        if (inc && !dec) begin
            res = cur + CNT_ONE;
        end else if (dec && !inc) begin
            res = cur - CNT_ONE;
        end
        return res;
    endfunction

    // Status flags come straight from registers, so there is no input-to-output path.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign idle     = empty && (state == S_IDLE);

    // A flush swallows any write in the same cycle without flagging overflow;
    // a write into a full queue is dropped even if a pop frees a slot this cycle.
    assign push = wr_en && !full && !flush;
    assign drop = wr_en && full && !flush;

    // Sequencer next state; pops only when idle and the registered empty flag is low.
    always_comb begin
        state_next = state;
        start_next = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sequencer state register; a flush never touches it, so an in-flight byte completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start pulse and issued byte; tx_data holds its value until the next issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= start_next;
            if (pop) begin
                tx_data <= mem[rp];
            end
        end
    end

    // Byte storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers and fill count; flush rewinds both pointers to slot zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            count_q <= next_count(count_q, push, pop);
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clear_overflow) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a serial transmitter model with a matching
// receiver, a scoreboard of expected bytes, a vector table for the
// full/overflow sequence and hand-written sequences for the other corners.
module tb_uart_tx_queue;

    localparam int DEPTH      = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int CPB        = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 wr_en;
    logic [7:0]           wr_data;
    logic                 flush;
    logic                 clear_overflow;
    logic                 full;
    logic                 empty;
    logic [DEPTH_LOG2:0]  count;
    logic                 overflow;
    logic                 idle;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;

    uart_tx_queue #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .idle           (idle),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_done        (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int start_cnt;
    int done_cnt;
    int peak;
    logic [7:0] start_q [$];
    logic [7:0] rx_q [$];

    // Transmitter model: 10-bit frame, CPB clocks per bit, done high for two cycles.
    logic       hold_done;
    logic       ser;
    logic       busy_err;
    logic [9:0] frame;
    int         m_st;
    int         bi;
    int         mc;
    int         dc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st     <= 0;
            ser      <= 1'b1;
            tx_done  <= 1'b0;
            frame    <= '0;
            bi       <= 0;
            mc       <= 0;
            dc       <= 0;
            busy_err <= 1'b0;
        end else begin
            busy_err <= tx_start && (m_st != 0);
            case (m_st)
                0: begin
                    tx_done <= 1'b0;
                    ser     <= 1'b1;
                    if (tx_start) begin
                        frame <= {1'b1, tx_data, 1'b0};
                        ser   <= 1'b0;
                        bi    <= 0;
                        mc    <= 0;
                        m_st  <= 1;
                    end
                end
                1: begin
                    if (mc == CPB - 1) begin
                        mc <= 0;
                        if (bi == 9) begin
                            m_st <= 2;
                            ser  <= 1'b1;
                            dc   <= 0;
                        end else begin
                            bi  <= bi + 1;
                            ser <= frame[bi + 1];
                        end
                    end else begin
                        mc <= mc + 1;
                    end
                end
                default: begin
                    if (!hold_done) begin
                        tx_done <= 1'b1;
                        dc      <= dc + 1;
                        if (dc == 1) begin
                            m_st <= 0;
                        end
                    end
                end
            endcase
        end
    end

    // Serial receiver: samples each bit in the middle of its period.
    logic       rx_busy;
    logic       rx_vld;
    logic       rx_stop_bad;
    logic [7:0] rx_sh;
    logic [7:0] rx_byte;
    int         rxc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_busy     <= 1'b0;
            rx_vld      <= 1'b0;
            rx_stop_bad <= 1'b0;
            rx_sh       <= '0;
            rx_byte     <= '0;
            rxc         <= 0;
        end else begin
            rx_vld <= 1'b0;
            if (!rx_busy) begin
                if (ser == 1'b0) begin
                    rx_busy <= 1'b1;
                    rxc     <= 1;
                end
            end else begin
                rxc <= rxc + 1;
                if (((rxc - 1) % CPB) == CPB / 2) begin
                    if (((rxc - 1) / CPB) >= 1 && ((rxc - 1) / CPB) <= 8) begin
                        rx_sh <= {ser, rx_sh[7:1]};
                    end
                    if (((rxc - 1) / CPB) == 9) begin
                        rx_busy     <= 1'b0;
                        rx_vld      <= 1'b1;
                        rx_byte     <= rx_sh;
                        rx_stop_bad <= !ser;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        start_q.push_back(d);
        rx_q.push_back(d);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Watches the handshake and the serial line, comparing against the scoreboard.
    task automatic monitor();
        logic       done_prev;
        logic [7:0] e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tx_start) begin
                    start_cnt++;
                    if (start_q.size() == 0) begin
                        chk("unexpected_start", 32'(tx_start), 32'd0);
                    end else begin
                        e = start_q.pop_front();
                        chk("start_data", 32'(tx_data), 32'(e));
                    end
                end
                if (tx_done && !done_prev) begin
                    done_cnt++;
                end
                if (rx_vld) begin
                    chk("rx_stop_bit", 32'(rx_stop_bad), 32'd0);
                    if (rx_q.size() == 0) begin
                        chk("unexpected_rx", 32'(rx_vld), 32'd0);
                    end else begin
                        e = rx_q.pop_front();
                        chk("rx_data", 32'(rx_byte), 32'(e));
                    end
                end
                if (busy_err) begin
                    chk("start_while_busy", 32'(busy_err), 32'd0);
                end
                if (int'(count) > peak) begin
                    peak = int'(count);
                end
            end
            done_prev = tx_done;
        end
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while (!(idle && start_q.size() == 0 && rx_q.size() == 0) && k < bound) begin
            step();
            k++;
        end
        chk({name, "_drain_in_time"}, 32'(k < bound), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"},  32'(tx_data),  32'h00);
        chk({tag, "_count"},    32'(count),    32'd0);
        chk({tag, "_empty"},    32'(empty),    32'd1);
        chk({tag, "_full"},     32'(full),     32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_idle"},     32'(idle),     32'd1);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       clr;
        logic       fl;
        logic       acc;
        logic [4:0] ecnt;
        logic       efull;
        logic       eempty;
        logic       eovf;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic clr,
                                input logic fl, input logic acc, input int ecnt,
                                input logic efull, input logic eempty, input logic eovf);
        vec_t v;
        v.wr     = wr;
        v.d      = d;
        v.clr    = clr;
        v.fl     = fl;
        v.acc    = acc;
        v.ecnt   = 5'(ecnt);
        v.efull  = efull;
        v.eempty = eempty;
        v.eovf   = eovf;
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        int s0;
        int d0;
        int gap;
        int w;
        logic [7:0] d;

        n_cmp          = 0;
        n_fail         = 0;
        start_cnt      = 0;
        done_cnt       = 0;
        peak           = 0;
        reset_n        = 1'b0;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        hold_done      = 1'b0;

        // Full/overflow vectors: 18 writes with done held low, then set-vs-clear.
        for (int i = 0; i < 18; i++) begin
            tbl[i] = mk(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, (i <= 16),
                        (i == 0) ? 1 : ((i < 16) ? i : 16), (i >= 16), 1'b0, (i == 17));
        end
        tbl[18] = mk(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0);

        fork
            monitor();
        join_none

        #1;
        chk_reset("por");
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single byte: start pulse two cycles after the write, exactly one cycle wide.
        s0 = start_cnt;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        push_exp(8'hA5);
        step();
        wr_en = 1'b0;
        chk("single_start_e0", 32'(tx_start), 32'd0);
        chk("single_count_e0", 32'(count), 32'd1);
        chk("single_empty_e0", 32'(empty), 32'd0);
        step();
        chk("single_start_e1", 32'(tx_start), 32'd1);
        chk("single_data_e1", 32'(tx_data), 32'hA5);
        chk("single_count_e1", 32'(count), 32'd0);
        step();
        chk("single_start_e2", 32'(tx_start), 32'd0);
        chk("single_idle_busy", 32'(idle), 32'd0);
        drain("single", 200);
        repeat (5) step();
        chk("single_starts", 32'(start_cnt - s0), 32'd1);
        chk("single_idle_after", 32'(idle), 32'd1);

        // Burst of five consecutive writes.
        s0 = start_cnt;
        d0 = done_cnt;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            push_exp(8'(i));
            step();
        end
        wr_en = 1'b0;
        drain("burst", 600);
        repeat (5) step();
        chk("burst_peak_count", 32'(peak), 32'd4);
        chk("burst_starts", 32'(start_cnt - s0), 32'd5);
        chk("burst_dones", 32'(done_cnt - d0), 32'd5);

        // Full and overflow from the vector table, then drain.
        hold_done = 1'b1;
        for (int r = 0; r < 21; r++) begin
            wr_en          = tbl[r].wr;
            wr_data        = tbl[r].d;
            clear_overflow = tbl[r].clr;
            flush          = tbl[r].fl;
            if (tbl[r].wr && tbl[r].acc) begin
                push_exp(tbl[r].d);
            end
            step();
            chk($sformatf("tbl%0d_count", r),    32'(count),    32'(tbl[r].ecnt));
            chk($sformatf("tbl%0d_full", r),     32'(full),     32'(tbl[r].efull));
            chk($sformatf("tbl%0d_empty", r),    32'(empty),    32'(tbl[r].eempty));
            chk($sformatf("tbl%0d_overflow", r), 32'(overflow), 32'(tbl[r].eovf));
        end
        wr_en = 1'b0;
        clear_overflow = 1'b0;
        hold_done = 1'b0;
        drain("full", 2000);

        // Wrap-around: 40 random bytes with random gaps, never writing while full.
        s0 = start_cnt;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b0;
            gap = int'($urandom_range(0, 3));
            repeat (gap) step();
            w = 0;
            while (full && w < 500) begin
                step();
                w++;
            end
            chk($sformatf("wrap%0d_full_wait", i), 32'(w < 500), 32'd1);
            d = 8'($urandom_range(0, 255));
            wr_en = 1'b1;
            wr_data = d;
            push_exp(d);
            step();
        end
        wr_en = 1'b0;
        drain("wrap", 2500);
        chk("wrap_starts", 32'(start_cnt - s0), 32'd40);
        chk("wrap_overflow", 32'(overflow), 32'd0);

        // Flush with five queued bytes and a simultaneous write.
        s0 = start_cnt;
        hold_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hB0 + i);
            push_exp(8'(8'hB0 + i));
            step();
        end
        chk("flush_count_before", 32'(count), 32'd5);
        wr_en = 1'b1;
        wr_data = 8'hEE;
        flush = 1'b1;
        step();
        wr_en = 1'b0;
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_overflow", 32'(overflow), 32'd0);
        chk("flush_idle_inflight", 32'(idle), 32'd0);
        repeat (5) begin
            void'(start_q.pop_back());
            void'(rx_q.pop_back());
        end
        hold_done = 1'b0;
        drain("flush", 300);
        repeat (10) step();
        chk("flush_starts", 32'(start_cnt - s0), 32'd1);
        chk("flush_idle_after", 32'(idle), 32'd1);

        // Asynchronous reset mid-stream with the queue full and overflow set.
        hold_done = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hC0 + i);
            if (i <= 16) begin
                push_exp(8'(8'hC0 + i));
            end
            step();
        end
        wr_en = 1'b0;
        chk("rst_pre_overflow", 32'(overflow), 32'd1);
        chk("rst_pre_count", 32'(count), 32'd16);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("async_rst");
        start_q.delete();
        rx_q.delete();
        step();
        step();
        reset_n = 1'b1;
        hold_done = 1'b0;
        s0 = start_cnt;
        repeat (20) step();
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_starts", 32'(start_cnt - s0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and issue sequencer sitting directly upstream of the UART transmitter. It accepts bytes from the memory-mapped I/O write path into a DEPTH-entry FIFO. It then hands them one at a time to the transmitter over its start/data/done handshake, so the CPU can queue bytes without polling the transmitter per byte. It reports fill level, empty/full, idle, and a sticky overflow flag for the I/O status register.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- DEPTH_LOG2, 4: log2(DEPTH); pointer width.
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to queue.
- flush  in  1  discard all queued bytes.
- clear_overflow  in  1  clear the overflow flag.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  DEPTH_LOG2+1  bytes currently queued, excluding the in-flight byte.
- overflow  out  1  sticky; set when a write was dropped because the FIFO was full.
- idle  out  1  empty and sequencer in S_IDLE.
- tx_start  out  1  single-cycle start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; valid while tx_start is high and held until the next issue.
- tx_done  in  1  transmitter completion; high for one or more cycles after the stop bit.

## Operation
- Storage:
  - DEPTH x 8 register array.
  - Read and write pointers of DEPTH_LOG2 bits that wrap modulo DEPTH.
  - A separate count register; full and empty are derived from count.
- Push: when wr_en=1, full=0 and flush=0, write mem[wp] and increment wp.
- Drop: when wr_en=1 and full=1, the byte is dropped, pointers are unchanged, and overflow is set. This holds even if a pop occurs in the same cycle.
- Pop: happens only on issue (S_IDLE with empty=0). The sequencer registers tx_data<=mem[rp], increments rp, and decrements count.
- Push and pop in the same cycle leave count unchanged. On an empty FIFO a push is never popped in its own cycle, because empty is registered.
- Flush:
  - Sets rp=wp=0 and count=0.
  - A simultaneous write is dropped and does not set overflow.
  - Does not abort an in-flight byte; the sequencer state is unchanged.
- Overflow: clear_overflow clears it. If a set and a clear land in the same cycle, the set wins.
- Sequencer states:
  - S_IDLE: tx_start=0. If empty=0, pop, tx_start<=1, go to S_START.
  - S_START: tx_start<=0 (the pulse lasts exactly one cycle). Go to S_WAIT.
  - S_WAIT: hold tx_start=0. When tx_done=1, go to S_IDLE. Remaining high done cycles are ignored because the state only re-arms in S_IDLE. The transmitter is back in its idle state by the cycle in which it drives done.
  - Any illegal state encoding returns to S_IDLE.
- tx_start is never high while a byte is in flight. At most one byte is outstanding.

## Timing
- Reset values (async on reset_n=0): tx_start=0, tx_data=0x00, count=0, empty=1, full=0, overflow=0, idle=1, pointers=0, state S_IDLE. FIFO contents are don't-care.
- Reset deassertion: the block operates from the first rising edge after reset_n rises.
- Reset mid-transmission returns the block to the reset values. The transmitter has its own reset and is not waited on.
- Latency: wr_en sampled at edge 0 into an empty idle queue gives count=1 and empty=0 after edge 0. tx_start is high between edge 1 and edge 2, and count=0 after edge 1.
- Back-to-back: tx_done sampled high at edge N gives S_IDLE after N. The next tx_start is high after edge N+1. This gives one gap cycle between completion and the next start.
- full, empty, count, overflow and idle are all registered outputs; there is no combinational path from the inputs.

## Test plan
- Reset: hold reset_n=0 mid-stream -> all outputs at reset values immediately, without a clock; queue empty afterwards.
- Single byte: write 0xA5 into an idle queue -> tx_start high exactly one cycle, two cycles after the write, with tx_data=0xA5. Then no further tx_start until tx_done, after which idle=1.
- Burst with a transmitter model (CLKS_PER_BIT=4): write 0x01..0x05 on consecutive cycles -> serial output decodes 01,02,03,04,05 in order. Exactly one start per done, and count peaks at 4.
- Full and overflow with DEPTH=16 and tx_done held low: write 18 bytes -> 1 in flight, count=16, full=1, overflow=1. Write 0x77 and clear_overflow in the same cycle -> overflow stays 1. clear_overflow alone -> 0.
- Wrap-around: run 40 bytes through DEPTH=16 with random write gaps -> output order and values match the input exactly.
- Flush mid-stream: flush with 5 queued bytes and a simultaneous write -> count=0, overflow unchanged. The in-flight byte still completes, and no further tx_start is issued.
